// File: rtl/serial_shift_ctrl.sv
// serial_shift_ctrl: frame sequencer plus TX/RX shift registers for an NBITS-long serial frame.
// Generates a one-cycle load strobe, a divided 50%-duty serial clock, a bit counter and a
// done pulse, and supports back-to-back (continuous) framing and MSB/LSB-first bit order.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   start    in   frame request (honoured in IDLE and FINISH only)
//   cont     in   continuous mode, chains the next frame directly out of FINISH
//   tx_data  in   parallel word, captured in the shld cycle
//   sdi      in   serial data in, sampled on the serclk rising edge
//   shld     out  load strobe, one cycle at frame start
//   serclk   out  serial clock, period 2*DIV clk
//   sdo      out  serial data out
//   rx_data  out  last completely received word
//   count    out  bits completed in the current or last frame
//   busy     out  high from shld through done inclusive
//   done     out  one-cycle pulse at frame completion
module serial_shift_ctrl #(
  parameter int unsigned NBITS     = 16,
  parameter int unsigned CW        = 8,
  parameter int unsigned DIV       = 1,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic [NBITS-1:0] tx_data,
  input  logic             sdi,
  output logic             shld,
  output logic             serclk,
  output logic             sdo,
  output logic [NBITS-1:0] rx_data,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] LO     = 3'd2;
  localparam logic [2:0] HI     = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam int unsigned   DW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE    = DW'(1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(NBITS);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [DW-1:0]    div_cnt;
  logic [NBITS-1:0] tx_sr;
  logic [NBITS-1:0] rx_sr;
  logic [NBITS-1:0] tx_sr_shifted;
  logic [NBITS-1:0] rx_sr_shifted;
  logic             phase_end;
  logic             last_bit;

  assign phase_end = (div_cnt == DIV_LAST);
  assign last_bit  = ((count + COUNT_ONE) == COUNT_LAST);

  // Received bits enter from the end opposite to the one being transmitted, so a
  // loopback (sdi tied to sdo) reassembles tx_data unchanged.
  assign tx_sr_shifted = LSB_FIRST ? {1'b0, tx_sr[NBITS-1:1]} : {tx_sr[NBITS-2:0], 1'b0};
  assign rx_sr_shifted = LSB_FIRST ? {sdi, rx_sr[NBITS-1:1]} : {rx_sr[NBITS-2:0], sdi};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = LO;
      LO:      if (phase_end) state_next = HI;
      HI:      if (phase_end) state_next = last_bit ? FINISH : LO;
      FINISH:  state_next = (cont || start) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      count   <= '0;
    end else begin
      state <= state_next;
      case (state)
        LOAD: begin
          tx_sr   <= tx_data;
          div_cnt <= '0;
        end
        LO: begin
          if (phase_end) begin
            // Edge entering HI is the serclk rising edge: capture sdi here.
            div_cnt <= '0;
            rx_sr   <= rx_sr_shifted;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        HI: begin
          if (phase_end) begin
            div_cnt <= '0;
            count   <= count + COUNT_ONE;
            tx_sr   <= tx_sr_shifted;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        FINISH:  rx_data <= rx_sr;
        default: ;
      endcase
      // Count reads zero during LOAD; it holds NBITS through FINISH and IDLE otherwise.
      if (state_next == LOAD) count <= '0;
    end
  end

  always_comb begin
    shld   = (state == LOAD);
    serclk = (state == HI);
    busy   = (state != IDLE);
    done   = (state == FINISH);
    sdo    = 1'b0;
    if ((state == LO) || (state == HI)) begin
      sdo = LSB_FIRST ? tx_sr[0] : tx_sr[NBITS-1];
    end
  end

endmodule
